// File: rtl/ibex_mem_resp_pkg.sv
// ----------------------------------------------------------------------------
// ibex_mem_resp_pkg
// Shared types and helpers for the Ibex bus memory responder.
//   mem_resp_t    : one response beat {err, rdata}
//   addr_in_range : byte-address window check, evaluated in 33 bits so that
//                   a window that ends exactly at 2^32 does not wrap.
// ----------------------------------------------------------------------------
package ibex_mem_resp_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;

  typedef struct packed {
    logic             err;
    logic [DataW-1:0] rdata;
  } mem_resp_t;

  // True iff base <= addr < base + 4*words.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] words);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + ({1'b0, words} << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// ----------------------------------------------------------------------------
// ibex_mem_resp_pipe
// Fixed-latency response delay line: Latency stages of {valid, mem_resp_t}.
// A beat loaded at edge N appears on the output during the cycle after edge
// N+Latency-1. Output payload is forced to zero whenever the output is not
// valid, so downstream never sees stale data.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears valid bits)
//   in_valid_i     load a response beat this edge
//   in_resp_i      response payload to load
//   out_valid_o    response beat valid this cycle
//   out_resp_o     response payload (zero when out_valid_o is low)
// ----------------------------------------------------------------------------
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      in_valid_i,
  input  mem_resp_t in_resp_i,
  output logic      out_valid_o,
  output mem_resp_t out_resp_o
);

  logic [Latency-1:0] valid_q;
  mem_resp_t          resp_q [Latency];

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // stage samples the value its neighbour held before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      for (int i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; only the valid bits
  // carry control meaning, and the output gating below hides any junk.
  always_ff @(posedge clk_i) begin
    resp_q[0] <= in_resp_i;
    for (int i = 1; i < Latency; i++) begin
      resp_q[i] <= resp_q[i-1];
    end
  end

  assign out_valid_o = valid_q[Latency-1];
  assign out_resp_o  = valid_q[Latency-1] ? resp_q[Latency-1] : '0;

endmodule

// File: rtl/ibex_mem_responder.sv
// ----------------------------------------------------------------------------
// ibex_mem_responder
// Memory-side responder for the Ibex req/gnt/rvalid/err bus. Word-addressed
// RAM behind a byte-address window, in-order responses after a fixed
// Latency, at most MaxOutstanding granted-but-unanswered requests.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i/gnt_o    request handshake (gnt_o is combinational)
//   we_i, be_i     write enable and byte enables
//   addr_i         byte address, bits [1:0] ignored
//   wdata_i        write data
//   stall_i        test hook, suppresses gnt_o while high
//   rvalid_o       one-cycle response pulse per accepted request
//   rdata_o        read data (0 for writes, errors and idle cycles)
//   err_o          access fell outside the RAM window
// ----------------------------------------------------------------------------
module ibex_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             we_i,
  input  logic [BeW-1:0]   be_i,
  input  logic [31:0]      addr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             stall_i,
  output logic             rvalid_o,
  output logic [DataW-1:0] rdata_o,
  output logic             err_o
);

  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [DataW-1:0] mem_q [MemWords];
  logic [CntW-1:0]  outstanding_q;
  logic [CntW-1:0]  outstanding_d;

  logic             in_range;
  logic [IdxW-1:0]  idx;
  logic             accept;
  mem_resp_t        resp_d;
  mem_resp_t        resp_out;

  // ---------------------------------------------------------------- decode
  assign in_range = addr_in_range(addr_i, BaseAddr, 32'(MemWords));
  // Out-of-range addresses alias to some index; every use is gated by in_range.
  assign idx      = IdxW'((addr_i - BaseAddr) >> 2);

  // ----------------------------------------------------------------- grant
  // rst_ni in the product keeps gnt_o low while reset is held, even with
  // req_i already asserted by the initiator.
  assign gnt_o  = rst_ni & req_i & ~stall_i &
                  (outstanding_q < CntW'(MaxOutstanding));
  assign accept = req_i & gnt_o;

  // ---------------------------------------------------------------- RAM
  // Plain clocked process: RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < BeW; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response for the request being accepted this cycle. The read sees the RAM
  // as of the accept edge, i.e. every write accepted on an earlier edge.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path
    // leaves it unassigned and a latch is never inferred.
    resp_d     = '0;
    resp_d.err = ~in_range;
    if (in_range && !we_i) begin
      resp_d.rdata = mem_q[idx];
    end
  end

  ibex_mem_resp_pipe #(
    .Latency (Latency)
  ) u_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (accept),
    .in_resp_i   (resp_d),
    .out_valid_o (rvalid_o),
    .out_resp_o  (resp_out)
  );

  assign rdata_o = resp_out.rdata;
  assign err_o   = resp_out.err;

  // ------------------------------------------------------ outstanding count
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({accept, rvalid_o})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // ------------------------------------------------------------ assertions
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_q <= CntW'(MaxOutstanding));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> (outstanding_q != '0));

endmodule

// File: tb/tb_ibex_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_ibex_mem_responder
// Two responders share one set of bus inputs: u_dut1 (Latency 1, default
// MaxOutstanding 2) and u_dut3 (Latency 3, MaxOutstanding 3). Single accesses
// are checked on u_dut1; pipelining, stall and reset-in-flight on u_dut3.
// ----------------------------------------------------------------------------
module tb_ibex_mem_responder;

  localparam logic [31:0] Base = 32'h0010_0000;
  localparam int unsigned Words = 1024;

  typedef bit seq_t [10];
  typedef int idx_t [10];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, stall;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ibex_mem_responder #(
    .BaseAddr(Base), .MemWords(Words), .Latency(1), .MaxOutstanding(2)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
  );

  ibex_mem_responder #(
    .BaseAddr(Base), .MemWords(Words), .Latency(3), .MaxOutstanding(3)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
    .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
  endtask

  // Single access against u_dut1. Entered and left at posedge+1.
  task automatic access(input string tag, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int waited = 0;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
    while (!gnt1 && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    check({tag, "_gnt"}, gnt1, 1);
    @(posedge clk); #1;
    idle_inputs();
    check({tag, "_rvalid"}, rvalid1, 1);
    check({tag, "_rdata"}, rdata1, exp_rdata);
    check({tag, "_err"}, err1, exp_err);
    @(posedge clk); #1;
    check({tag, "_rvalid_off"}, rvalid1, 0);
  endtask

  // Cycle-table sequence of reads against u_dut3. Request k reads word
  // base_word+k, which holds 32'hA000_0000 + base_word + k.
  task automatic run_seq(input string name, input int nreq,
                         input int base_word, input seq_t stl,
                         input seq_t eg, input seq_t erv, input idx_t eidx);
    int k = 0;
    logic [31:0] expd;
    for (int c = 0; c < 10; c++) begin
      req   = (k < nreq);
      we    = 1'b0;
      addr  = Base + 32'h20 + 32'(4 * (base_word + k));
      stall = stl[c];
      #1;
      expd = erv[c] ? 32'hA000_0000 + 32'(base_word + eidx[c]) : 32'h0;
      check($sformatf("%s_gnt_c%0d", name, c), gnt3, eg[c]);
      check($sformatf("%s_rvalid_c%0d", name, c), rvalid3, erv[c]);
      check($sformatf("%s_rdata_c%0d", name, c), rdata3, expd);
      check($sformatf("%s_err_c%0d", name, c), err3, 0);
      if (req && gnt3) k++;
      @(posedge clk); #1;
    end
    idle_inputs();
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_t z  = '{default: 0};
    idx_t zi = '{default: 0};
    seq_t b_g  = '{1,1,1,0,1,1,0,0,0,0};
    seq_t b_rv = '{0,0,0,1,1,1,0,1,1,0};
    idx_t b_ix = '{0,0,0,0,1,2,0,3,4,0};
    seq_t s_st = '{0,1,1,1,1,0,0,0,0,0};
    seq_t s_g  = '{1,0,0,0,0,1,0,0,0,0};
    seq_t s_rv = '{0,0,0,1,0,0,0,0,1,0};
    idx_t s_ix = '{0,0,0,0,0,0,0,0,1,0};
    seq_t r_g  = '{1,0,0,0,0,0,0,0,0,0};
    seq_t r_rv = '{0,0,0,1,0,0,0,0,0,0};

    // Reset with a request already pending: grant must stay low.
    rst_n = 1'b0; stall = 1'b0;
    idle_inputs();
    req = 1'b1; addr = Base;
    #2;
    check("rst_gnt1", gnt1, 0);
    check("rst_gnt3", gnt3, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_err1", err1, 0);
    check("rst_rvalid3", rvalid3, 0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    #1;
    check("idle_gnt1", gnt1, 0);
    check("idle_rvalid1", rvalid1, 0);
    check("idle_rdata1", rdata1, 0);
    check("idle_err1", err1, 0);
    @(posedge clk); #1;

    // Stalled request never granted, never answered.
    req = 1'b1; stall = 1'b1; addr = Base;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("stall_gnt1_c%0d", c), gnt1, 0);
      check($sformatf("stall_gnt3_c%0d", c), gnt3, 0);
      check($sformatf("stall_rv1_c%0d", c), rvalid1, 0);
      check($sformatf("stall_rv3_c%0d", c), rvalid3, 0);
      @(posedge clk); #1;
    end
    idle_inputs();
    stall = 1'b0;
    @(posedge clk); #1;

    // Full-word write then read back.
    access("wr_beef", 1'b1, 4'hF, Base + 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("rd_beef", 1'b0, 4'h0, Base + 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Partial write over a known word, then a be==0 no-op write.
    access("wr_1111", 1'b1, 4'hF, Base + 32'hC, 32'h1111_1111, 32'h0, 1'b0);
    access("wr_part", 1'b1, 4'b0010, Base + 32'hC, 32'h0000_AB00, 32'h0, 1'b0);
    access("rd_part", 1'b0, 4'h0, Base + 32'hC, 32'h0, 32'h1111_AB11, 1'b0);
    access("wr_be0", 1'b1, 4'h0, Base + 32'hC, 32'hFFFF_FFFF, 32'h0, 1'b0);
    access("rd_be0", 1'b0, 4'h0, Base + 32'hC, 32'h0, 32'h1111_AB11, 1'b0);

    // Window edges. Both out-of-range addresses alias to word 0 inside the
    // index arithmetic, so a leaked write would corrupt it.
    access("wr_w0", 1'b1, 4'hF, Base, 32'h1234_5678, 32'h0, 1'b0);
    access("rd_below", 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    access("rd_above", 1'b0, 4'h0, Base + 32'(4 * Words), 32'h0, 32'h0, 1'b1);
    access("wr_below", 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    access("wr_above", 1'b1, 4'hF, Base + 32'(4 * Words), 32'hFFFF_FFFF,
           32'h0, 1'b1);
    access("rd_w0", 1'b0, 4'h0, Base, 32'h0, 32'h1234_5678, 1'b0);
    access("wr_last", 1'b1, 4'hF, Base + 32'(4 * Words - 4), 32'hCAFE_F00D,
           32'h0, 1'b0);
    access("rd_last", 1'b0, 4'h0, Base + 32'(4 * Words - 4), 32'h0,
           32'hCAFE_F00D, 1'b0);

    // Preload words used by the pipelined sequences (both RAMs see them).
    for (int i = 0; i < 5; i++) begin
      access($sformatf("pre_w%0d", i), 1'b1, 4'hF, Base + 32'h20 + 32'(4 * i),
             32'hA000_0000 + 32'(i), 32'h0, 1'b0);
    end
    repeat (4) @(posedge clk);
    #1;

    // Latency 3 / MaxOutstanding 3: five back-to-back reads.
    run_seq("burst", 5, 0, z, b_g, b_rv, b_ix);
    repeat (3) @(posedge clk);
    #1;

    // Stall mid-burst blocks grants but the in-flight read still drains.
    run_seq("midstall", 2, 0, s_st, s_g, s_rv, s_ix);
    repeat (3) @(posedge clk);
    #1;

    // Reset with two reads in flight on u_dut3.
    req = 1'b1; addr = Base + 32'h20;
    #1;
    check("rif_gnt_a", gnt3, 1);
    @(posedge clk); #1;
    addr = Base + 32'h24;
    #1;
    check("rif_gnt_b", gnt3, 1);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rif_rst_rvalid3", rvalid3, 0);
    check("rif_rst_rvalid1", rvalid1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rif_post_rv3_c%0d", c), rvalid3, 0);
      check($sformatf("rif_post_rv1_c%0d", c), rvalid1, 0);
      @(posedge clk); #1;
    end

    // Next read after reset completes normally.
    run_seq("post_rst", 1, 2, z, r_g, r_rv, zi);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
